instr_fetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the execute stage. It replaces the combinational PC-indexed instruction memory lookup with a pipelined request/grant/response fetch and a small prefetch FIFO. It delivers in-order {instr, pc} pairs to the execute stage over a valid/ready handshake. Branch or jump redirects from downstream flush the FIFO and discard in-flight responses.

---
 rtl/toothless_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/toothless_pkg.sv
// Shared fetch-front-end constants.
// Latency: n/a (constants only).
// Backpressure: n/a.
package toothless_pkg;

    // Default prefetch depth; also bounds the number of outstanding fetches.
    localparam int FETCH_FIFO_DEPTH = 4;

    // Instructions are word aligned: the low address bits are always zero.
    localparam int INSTR_ALIGN_BITS = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush, pointer-based with a wrap bit.
// Latency: a push is visible on rdata_o the cycle after it is written (registered head).
// Backpressure: full_o/empty_o; push at full is legal only together with a pop.
// Ports: clk, rst (sync, active high), flush_i (empties the FIFO, wins over push/pop),
//        push_i/wdata_i write side, pop_i/rdata_o read side, empty_o, full_o, count_o.
module fetch_fifo
    import toothless_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    // Pointers differ only in the wrap bit when full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so push at full is accepted then.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i));

endmodule

// File: rtl/instr_fetch_unit.sv
// Pipelined instruction fetch with prefetch FIFO and redirect flush.
// Latency: grant in cycle t, rvalid in t+1, instr_valid_o in t+2 (no bypass).
// Backpressure: fetches stall when FIFO entries plus outstanding requests reach FIFO_DEPTH.
// Ports: clk/rst (sync, active high); instr_req_o/instr_addr_o/instr_gnt_i request channel;
//        instr_rvalid_i/instr_rdata_i in-order responses; instr_valid_o/instr_ready_i/
//        instr_o/instr_pc_o to execute; redirect_i/redirect_addr_i flush and refetch.
module instr_fetch_unit
    import toothless_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    FIFO_DEPTH  = FETCH_FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   instr_req_o,
    output logic [ADDR_WIDTH-1:0]  instr_addr_o,
    input  logic                   instr_gnt_i,
    input  logic                   instr_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr_i
);

    localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]           DEPTH_W    = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] INSTR_STEP = ADDR_WIDTH'(1 << INSTR_ALIGN_BITS);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    logic                  rst_q;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         discard_q, discard_d;

    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  grant;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] target;
    fetch_entry_t          wr_entry;
    fetch_entry_t          head;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^redirect_addr_i[INSTR_ALIGN_BITS-1:0];
    assign target = {redirect_addr_i[ADDR_WIDTH-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};

    // Every slot is reserved at issue time, so a response can never find the FIFO full.
    assign occupancy    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign instr_req_o  = !rst_q && (occupancy < DEPTH_W) && !redirect_i;
    assign instr_addr_o = fetch_addr_q;
    assign grant        = instr_req_o && instr_gnt_i;

    // Responses that belong to a flushed path are dropped until discard drains.
    assign push     = instr_rvalid_i && (discard_q == '0) && !redirect_i;
    assign pop      = !fifo_empty && instr_ready_i;
    assign wr_entry = '{pc: resp_pc_q, instr: instr_rdata_i};

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(instr_rvalid_i);
        if (redirect_i) begin
            // No grant is possible here; what remains in flight after this
            // cycle's response is exactly what must be thrown away.
            fetch_addr_d = target;
            resp_pc_d    = target;
            discard_d    = outstanding_q - CW'(instr_rvalid_i);
        end else begin
            if (grant) fetch_addr_d = fetch_addr_q + INSTR_STEP;
            if (push)  resp_pc_d    = resp_pc_q + INSTR_STEP;
            if (instr_rvalid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q         <= 1'b1;
            fetch_addr_q  <= BOOT_ADDR;
            resp_pc_q     <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            rst_q         <= 1'b0;
            fetch_addr_q  <= fetch_addr_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Storage is unreset, so the head is masked to zero while empty.
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? '0 : head.instr;
    assign instr_pc_o    = fifo_empty ? '0 : head.pc;

    a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(instr_rvalid_i && (outstanding_q == '0)));

    a_full_implies_no_req: assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && instr_req_o));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;

    int          n_cmp;
    int          n_err;
    int          n_grants;
    logic        rsp_en;
    logic [31:0] pend [$];

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are sampled at the falling edge, the memory model
    // updates at the rising edge and presents the oldest pending response
    // 1 ns later; returns 2 ns after the rising edge.
    task automatic tick();
        logic        fire;
        logic        rsp;
        logic [31:0] a;
        @(negedge clk);
        fire = instr_req_o && instr_gnt_i;
        rsp  = instr_rvalid_i;
        a    = instr_addr_o;
        @(posedge clk);
        if (rst) begin
            pend.delete();
        end else begin
            if (rsp && pend.size() > 0) void'(pend.pop_front());
            if (fire === 1'b1) begin
                pend.push_back(a);
                n_grants++;
            end
        end
        #1;
        if (rsp_en && pend.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(pend[0]);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        instr_gnt_i = 1'b0;
        instr_ready_i = 1'b0;
        rsp_en      = 1'b0;
        redirect_i  = 1'b0;
        tick();
        rst      = 1'b0;
        n_grants = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_grants = 0;
        rst = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
        instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0; rsp_en = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req",   {31'd0, instr_req_o},   32'd0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o,    32'd0);
        chk("rst_pc",    instr_pc_o, 32'd0);
        rst = 1'b0; #1;
        chk("rst_hold_req", {31'd0, instr_req_o}, 32'd0);

        // 1. Streaming at one instruction per cycle
        instr_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b1;
        tick();
        chk("s_first_req",  {31'd0, instr_req_o}, 32'd1);
        chk("s_first_addr", instr_addr_o, 32'h0);
        chk("s_valid_c1",   {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("s_valid_c2",   {31'd0, instr_valid_o}, 32'd0);
        chk("s_addr_c2",    instr_addr_o, 32'h4);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("s_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("s_pc",    instr_pc_o, 32'(4 * i));
            chk("s_instr", instr_o,    mem_word(32'(4 * i)));
            tick();
        end

        // 2. Backpressure: FIFO fills after exactly 4 grants
        do_reset();
        instr_gnt_i = 1'b1; instr_ready_i = 1'b0; rsp_en = 1'b1;
        repeat (8) tick();
        chk("bp_grants", 32'(n_grants), 32'd4);
        chk("bp_req",    {31'd0, instr_req_o},   32'd0);
        chk("bp_valid",  {31'd0, instr_valid_o}, 32'd1);
        chk("bp_pc",     instr_pc_o, 32'h0);
        tick(); tick();
        chk("bp_pc_hold",    instr_pc_o, 32'h0);
        chk("bp_instr_hold", instr_o,    mem_word(32'h0));
        chk("bp_req_hold",   {31'd0, instr_req_o}, 32'd0);
        instr_ready_i = 1'b1; #1;
        chk("dr_pc0", instr_pc_o, 32'h0);
        tick();
        chk("dr_pc4",    instr_pc_o, 32'h4);
        chk("dr_req",    {31'd0, instr_req_o}, 32'd1);
        chk("dr_resume", instr_addr_o, 32'h10);
        tick();
        chk("dr_pc8", instr_pc_o, 32'h8);
        tick();
        chk("dr_pcc", instr_pc_o, 32'hC);
        tick();
        chk("dr_pc10", instr_pc_o, 32'h10);

        // 3. Grant stall for three cycles at 0x8
        do_reset();
        instr_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b1;
        tick(); tick(); tick();
        instr_gnt_i = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("gs_req",  {31'd0, instr_req_o}, 32'd1);
            chk("gs_addr", instr_addr_o, 32'h8);
            tick();
        end
        chk("gs_addr_end", instr_addr_o, 32'h8);
        instr_gnt_i = 1'b1; #1;
        tick();
        chk("gs_next_addr", instr_addr_o, 32'hC);

        // 4. Redirect with two requests outstanding
        do_reset();
        instr_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b0;
        tick(); tick(); tick();
        chk("rd_pre_addr", instr_addr_o, 32'h8);
        redirect_i = 1'b1; redirect_addr_i = 32'h103; rsp_en = 1'b1; #1;
        chk("rd_req_low", {31'd0, instr_req_o}, 32'd0);
        tick();
        redirect_i = 1'b0; #1;
        chk("rd_req",    {31'd0, instr_req_o}, 32'd1);
        chk("rd_target", instr_addr_o, 32'h100);
        chk("rd_drop0",  {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("rd_drop1",  {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("rd_drop2",  {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("rd_valid",  {31'd0, instr_valid_o}, 32'd1);
        chk("rd_pc",     instr_pc_o, 32'h100);
        chk("rd_instr",  instr_o,    mem_word(32'h100));
        tick();
        chk("rd_pc_next", instr_pc_o, 32'h104);

        // 5. Redirect coinciding with rvalid and a pop of the branch
        redirect_i = 1'b1; redirect_addr_i = 32'h200; #1;
        chk("rc_req_low",  {31'd0, instr_req_o},    32'd0);
        chk("rc_rvalid",   {31'd0, instr_rvalid_i}, 32'd1);
        chk("rc_branch",   instr_pc_o, 32'h104);
        tick();
        redirect_i = 1'b0; #1;
        chk("rc_empty0", {31'd0, instr_valid_o}, 32'd0);
        chk("rc_addr",   instr_addr_o, 32'h200);
        tick();
        chk("rc_empty1", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("rc_valid",  {31'd0, instr_valid_o}, 32'd1);
        chk("rc_pc",     instr_pc_o, 32'h200);

        // 6. Reset mid-stream with a full FIFO
        instr_ready_i = 1'b0;
        repeat (8) tick();
        chk("mr_full_req",   {31'd0, instr_req_o},   32'd0);
        chk("mr_full_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("mr_full_instr", instr_o, mem_word(32'h200));
        rst = 1'b1;
        tick();
        chk("mr_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("mr_req",   {31'd0, instr_req_o},   32'd0);
        chk("mr_pc",    instr_pc_o, 32'h0);
        rst = 1'b0; #1;
        chk("mr_hold_req", {31'd0, instr_req_o}, 32'd0);
        tick();
        chk("mr_req_up", {31'd0, instr_req_o}, 32'd1);
        chk("mr_boot",   instr_addr_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
